// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: carries decode results to execute, with stall/flush,
// load-use hazard detection with automatic bubble insertion and a saturating bubble counter.
module idex_pipe_reg #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int CTRL_WIDTH     = 9,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CTRL_WIDTH-1:0]     ctrl_in,
  input  logic                      valid_in,
  input  logic [DATA_WIDTH-1:0]     pc4_in,
  input  logic [DATA_WIDTH-1:0]     rs_data_in,
  input  logic [DATA_WIDTH-1:0]     rt_data_in,
  input  logic [DATA_WIDTH-1:0]     imm_in,
  input  logic [REG_ADDR_WIDTH-1:0] rs_in,
  input  logic [REG_ADDR_WIDTH-1:0] rt_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  input  logic                      uses_rt_in,
  input  logic                      stall,
  input  logic                      flush,
  output logic [CTRL_WIDTH-1:0]     ctrl_out,
  output logic                      valid_out,
  output logic [DATA_WIDTH-1:0]     pc4_out,
  output logic [DATA_WIDTH-1:0]     rs_data_out,
  output logic [DATA_WIDTH-1:0]     rt_data_out,
  output logic [DATA_WIDTH-1:0]     imm_out,
  output logic [REG_ADDR_WIDTH-1:0] rs_out,
  output logic [REG_ADDR_WIDTH-1:0] rt_out,
  output logic [REG_ADDR_WIDTH-1:0] rd_out,
  output logic [REG_ADDR_WIDTH-1:0] dest_out,
  output logic                      hazard_stall,
  output logic [COUNT_WIDTH-1:0]    bubble_count
);

  localparam int RegDstBit  = 0;
  localparam int MemReadBit = 2;

  typedef enum logic [1:0] {
    actLoad,
    actHold,
    actFlush,
    actBubble
  } edgeAction_t;

  edgeAction_t edgeAction;
  logic        rsMatch;
  logic        rtMatch;
  logic        countFull;

  // EX holds a load whose target is a source of the decode instruction.
  assign rsMatch      = (rt_out == rs_in);
  assign rtMatch      = uses_rt_in && (rt_out == rt_in);
  assign hazard_stall = valid_out && ctrl_out[MemReadBit] && valid_in && (rsMatch || rtMatch);
  assign countFull    = &bubble_count;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    edgeAction = actLoad;
    if (flush) begin
      edgeAction = actFlush;
    end else if (stall) begin
      edgeAction = actHold;
    end else if (hazard_stall) begin
      edgeAction = actBubble;
    end
  end

  // NOTE: registered state uses non-blocking assignments so all fields update together on the edge.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_out     <= '0;
      valid_out    <= 1'b0;
      pc4_out      <= '0;
      rs_data_out  <= '0;
      rt_data_out  <= '0;
      imm_out      <= '0;
      rs_out       <= '0;
      rt_out       <= '0;
      rd_out       <= '0;
      dest_out     <= '0;
      bubble_count <= '0;
    end else if (edgeAction != actHold) begin
      // Bubbles still load the payload fields so their contents stay deterministic.
      pc4_out     <= pc4_in;
      rs_data_out <= rs_data_in;
      rt_data_out <= rt_data_in;
      imm_out     <= imm_in;
      rs_out      <= rs_in;
      rt_out      <= rt_in;
      rd_out      <= rd_in;
      dest_out    <= ctrl_in[RegDstBit] ? rd_in : rt_in;
      if (edgeAction == actLoad) begin
        valid_out <= valid_in;
        ctrl_out  <= valid_in ? ctrl_in : '0;
      end else begin
        valid_out <= 1'b0;
        ctrl_out  <= '0;
      end
      if (edgeAction == actBubble && !countFull) begin
        bubble_count <= bubble_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Directed bench for idex_pipe_reg; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_idex_pipe_reg;

  logic        clock;
  logic        reset_n;
  logic [8:0]  ctrl_in;
  logic        valid_in;
  logic [15:0] pc4_in, rs_data_in, rt_data_in, imm_in;
  logic [2:0]  rs_in, rt_in, rd_in;
  logic        uses_rt_in, stall, flush;

  logic [8:0]  ctrl_out, ctrl2;
  logic        valid_out, valid2;
  logic [15:0] pc4_out, rs_data_out, rt_data_out, imm_out;
  logic [15:0] pc42, rsData2, rtData2, imm2;
  logic [2:0]  rs_out, rt_out, rd_out, dest_out;
  logic [2:0]  rs2, rt2, rd2, dest2;
  logic        hazard_stall, hazard2;
  logic [7:0]  bubble_count;
  logic [1:0]  bubbleCount2;

  int total = 0;
  int bad   = 0;

  idex_pipe_reg dut (
    .clock(clock), .reset_n(reset_n), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .pc4_in(pc4_in), .rs_data_in(rs_data_in), .rt_data_in(rt_data_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .uses_rt_in(uses_rt_in),
    .stall(stall), .flush(flush), .ctrl_out(ctrl_out), .valid_out(valid_out),
    .pc4_out(pc4_out), .rs_data_out(rs_data_out), .rt_data_out(rt_data_out), .imm_out(imm_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .dest_out(dest_out),
    .hazard_stall(hazard_stall), .bubble_count(bubble_count)
  );

  idex_pipe_reg #(.COUNT_WIDTH(2)) dutSat (
    .clock(clock), .reset_n(reset_n), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .pc4_in(pc4_in), .rs_data_in(rs_data_in), .rt_data_in(rt_data_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .uses_rt_in(uses_rt_in),
    .stall(stall), .flush(flush), .ctrl_out(ctrl2), .valid_out(valid2),
    .pc4_out(pc42), .rs_data_out(rsData2), .rt_data_out(rtData2), .imm_out(imm2),
    .rs_out(rs2), .rt_out(rt2), .rd_out(rd2), .dest_out(dest2),
    .hazard_stall(hazard2), .bubble_count(bubbleCount2)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next state-update edge; inputs and checks happen mid-cycle.
  task automatic stepEdge();
    @(negedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] c, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [2:0] rd, input logic u);
    valid_in   = v;
    ctrl_in    = c;
    rs_in      = rs;
    rt_in      = rt;
    rd_in      = rd;
    uses_rt_in = u;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_ctrl"}, 32'(ctrl_out), 32'h0);
    check({tag, "_valid"}, 32'(valid_out), 32'h0);
    check({tag, "_pc4"}, 32'(pc4_out), 32'h0);
    check({tag, "_data"}, 32'({rs_data_out, rt_data_out}), 32'h0);
    check({tag, "_imm"}, 32'(imm_out), 32'h0);
    check({tag, "_idx"}, 32'({rs_out, rt_out, rd_out, dest_out}), 32'h0);
    check({tag, "_count"}, 32'(bubble_count), 32'h0);
    check({tag, "_hazard"}, 32'(hazard_stall), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 9'h000, 3'd0, 3'd0, 3'd0, 1'b0);
    pc4_in = '0; rs_data_in = '0; rt_data_in = '0; imm_in = '0;
    stall = 1'b0; flush = 1'b0;
    #3;
    checkAllZero("reset");
    #10 reset_n = 1'b1;

    // Reset mid-run; rs_in=0 against rt_out=0 also shows r0 is not special.
    stepEdge();
    drive(1'b1, 9'h1FF, 3'd0, 3'd0, 3'd0, 1'b0);
    pc4_in = 16'h0042; rs_data_in = 16'h1111; rt_data_in = 16'h2222; imm_in = 16'h3333;
    stepEdge();
    check("mid_ctrl", 32'(ctrl_out), 32'h1FF);
    check("mid_pc4", 32'(pc4_out), 32'h0042);
    check("r0_hazard", 32'(hazard_stall), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    #1 reset_n = 1'b1;

    // Pass-through with RegDst=1, then RegDst=0.
    drive(1'b1, 9'h0A5, 3'd1, 3'd3, 3'd5, 1'b0);
    imm_in = 16'hFFF0;
    stepEdge();
    check("pt_ctrl", 32'(ctrl_out), 32'h0A5);
    check("pt_dest_rd", 32'(dest_out), 32'd5);
    check("pt_imm", 32'(imm_out), 32'hFFF0);
    check("pt_valid", 32'(valid_out), 32'h1);
    check("pt_rs_data", 32'(rs_data_out), 32'h1111);
    drive(1'b1, 9'h0A4, 3'd1, 3'd3, 3'd5, 1'b0);
    #1 check("pt_no_hazard", 32'(hazard_stall), 32'h0);
    stepEdge();
    check("pt_ctrl2", 32'(ctrl_out), 32'h0A4);
    check("pt_dest_rt", 32'(dest_out), 32'd3);

    // Load-use on rs: one bubble, then the dependent instruction loads.
    drive(1'b1, 9'h004, 3'd1, 3'd2, 3'd7, 1'b0);
    stepEdge();
    drive(1'b1, 9'h021, 3'd2, 3'd5, 3'd6, 1'b0);
    pc4_in = 16'h0100;
    #1 check("lu_hazard", 32'(hazard_stall), 32'h1);
    stepEdge();
    check("lu_bubble_ctrl", 32'(ctrl_out), 32'h0);
    check("lu_bubble_valid", 32'(valid_out), 32'h0);
    check("lu_count", 32'(bubble_count), 32'd1);
    check("lu_hazard_drop", 32'(hazard_stall), 32'h0);
    stepEdge();
    check("lu_load_ctrl", 32'(ctrl_out), 32'h021);
    check("lu_load_pc4", 32'(pc4_out), 32'h0100);
    check("lu_count_hold", 32'(bubble_count), 32'd1);

    // rt dependence gated by uses_rt_in.
    drive(1'b1, 9'h004, 3'd0, 3'd4, 3'd1, 1'b0);
    stepEdge();
    drive(1'b1, 9'h021, 3'd1, 3'd4, 3'd6, 1'b0);
    #1 check("rt_gated", 32'(hazard_stall), 32'h0);
    uses_rt_in = 1'b1;
    #1 check("rt_used", 32'(hazard_stall), 32'h1);

    // Stall beats a pending hazard for three edges.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepEdge();
      check("stall_ctrl", 32'(ctrl_out), 32'h004);
      check("stall_rt", 32'(rt_out), 32'd4);
      check("stall_count", 32'(bubble_count), 32'd1);
    end
    check("stall_hazard_persists", 32'(hazard_stall), 32'h1);
    flush = 1'b1;
    stepEdge();
    check("flush_stall_ctrl", 32'(ctrl_out), 32'h0);
    check("flush_stall_valid", 32'(valid_out), 32'h0);
    check("flush_stall_count", 32'(bubble_count), 32'd1);
    stall = 1'b0; flush = 1'b0;

    // Flush during a hazard: bubble without counting.
    drive(1'b1, 9'h004, 3'd0, 3'd4, 3'd1, 1'b0);
    stepEdge();
    drive(1'b1, 9'h021, 3'd4, 3'd0, 3'd6, 1'b0);
    flush = 1'b1;
    #1 check("flush_hz_present", 32'(hazard_stall), 32'h1);
    stepEdge();
    check("flush_hz_valid", 32'(valid_out), 32'h0);
    check("flush_hz_count", 32'(bubble_count), 32'd1);
    flush = 1'b0;

    // Invalid decode slot loads with control cleared.
    drive(1'b0, 9'h1FF, 3'd1, 3'd2, 3'd3, 1'b0);
    stepEdge();
    check("inv_ctrl", 32'(ctrl_out), 32'h0);
    check("inv_valid", 32'(valid_out), 32'h0);
    check("inv_dest", 32'(dest_out), 32'd3);

    // Five hazard bubbles: 2-bit counter saturates at 3, 8-bit keeps counting.
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 9'h004, 3'd7, 3'd2, 3'd1, 1'b0);
      stepEdge();
      drive(1'b1, 9'h021, 3'd2, 3'd5, 3'd6, 1'b0);
      #1 check("sat_hazard", 32'(hazard2), 32'h1);
      stepEdge();
      check("sat_count2", 32'(bubbleCount2), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      check("sat_count8", 32'(bubble_count), 32'(i + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
